// File: rtl/phy_rx_lanes.sv
// Multi-lane serial receiver: per-lane comma alignment and sync qualification,
// per-lane deskew FIFOs, and unstriping of the lane bytes into WORD_W-bit words.
module phy_rx_lanes #(
  parameter int         LANES      = 2,
  parameter int         WORD_W     = 32,
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANES-1:0]  in_data_serie,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic [LANES-1:0]  lane_active,
  output logic              overflow_err
);

  localparam int NBYTES = WORD_W / 8;
  localparam int ROUNDS = NBYTES / LANES;
  localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(SYNC_COUNT + 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ACTIVE = 2'd2
  } lane_state_e;

  logic [LANES-1:0]   push_s;
  logic [LANES-1:0]   empty_s;
  logic [LANES-1:0]   drop_s;
  logic [8*LANES-1:0] rd_byte_s;
  logic               pop_s;

  // A word slice is consumed only when every lane can supply its byte, so lanes never reorder.
  assign pop_s = &(~empty_s);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lane_state_e     state_q, state_d;
    logic [6:0]      sr_q;
    logic [7:0]      nb_s;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push_l;
    logic            active_l;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]     used_s;
    logic            full_l;
    logic            do_push_s;

    assign nb_s = {sr_q, in_data_serie[gi]};

    // Lane FSM state, shifter and counters
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= ST_UNSYNC;
        sr_q      <= 7'd0;
        bit_cnt_q <= 3'd0;
        cnt_q     <= CW'(0);
      end else begin
        state_q   <= state_d;
        sr_q      <= nb_s[6:0];
        bit_cnt_q <= bit_cnt_d;
        cnt_q     <= cnt_d;
      end
    end

    // Lane FSM next state: bit-slip search while unsynced, byte-framed checks afterwards
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q + 3'd1;
      case (state_q)
        ST_UNSYNC: begin
          if (nb_s == COMMA) begin
            bit_cnt_d = 3'd0;
            cnt_d     = CW'(1);
            state_d   = (SYNC_COUNT == 1) ? ST_ACTIVE : ST_COUNT;
          end else begin
            state_d = ST_UNSYNC;
          end
        end
        ST_COUNT: begin
          if (bit_cnt_q != 3'd7) begin
            state_d = ST_COUNT;
          end else if (nb_s == COMMA) begin
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_d == CW'(SYNC_COUNT)) ? ST_ACTIVE : ST_COUNT;
          end else begin
            cnt_d   = CW'(0);
            state_d = ST_UNSYNC;
          end
        end
        ST_ACTIVE: begin
          state_d = ST_ACTIVE;
        end
        default: begin
          state_d = ST_UNSYNC;
          cnt_d   = CW'(0);
        end
      endcase
    end

    // Lane FSM outputs: commas are idle fill and never enter the FIFO
    always_comb begin
      push_l   = 1'b0;
      active_l = 1'b0;
      case (state_q)
        ST_ACTIVE: begin
          active_l = 1'b1;
          if (bit_cnt_q == 3'd7 && nb_s != COMMA) begin
            push_l = 1'b1;
          end else begin
            push_l = 1'b0;
          end
        end
        default: begin
          push_l   = 1'b0;
          active_l = 1'b0;
        end
      endcase
    end

    assign used_s    = wr_ptr_q - rd_ptr_q;
    assign full_l    = (used_s == FIFO_FULL);
    // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
    assign do_push_s = push_l & (~full_l | pop_s);

    assign push_s[gi]              = push_l;
    assign empty_s[gi]             = (used_s == {(AW + 1){1'b0}});
    assign drop_s[gi]              = push_l & full_l & ~pop_s;
    assign rd_byte_s[8*gi +: 8]    = mem_q[rd_ptr_q[AW-1:0]];
    assign lane_active[gi]         = active_l;

    // Deskew FIFO storage and pointers
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[j] <= 8'h00;
        end
        wr_ptr_q <= {(AW + 1){1'b0}};
        rd_ptr_q <= {(AW + 1){1'b0}};
      end else begin
        if (do_push_s) begin
          mem_q[wr_ptr_q[AW-1:0]] <= nb_s;
          wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
          wr_ptr_q <= wr_ptr_q;
        end
        if (pop_s) begin
          rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
          rd_ptr_q <= rd_ptr_q;
        end
      end
    end
  end

  logic [RW-1:0]     round_q, round_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] merged_s;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  // Byte k = round*LANES + lane lands at [WORD_W-1-8k -: 8], MSB byte first
  always_comb begin
    merged_s = word_q;
    for (int j = 0; j < NBYTES; j++) begin
      if (RW'(j / LANES) == round_q) begin
        merged_s[WORD_W-1-8*j -: 8] = rd_byte_s[8*(j % LANES) +: 8];
      end else begin
        merged_s[WORD_W-1-8*j -: 8] = word_q[WORD_W-1-8*j -: 8];
      end
    end
  end

  // Assembler next state: the last round publishes the word including this edge's bytes
  always_comb begin
    round_d = round_q;
    word_d  = word_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q | (|drop_s);
    if (pop_s) begin
      word_d = merged_s;
      if (round_q == LAST_ROUND) begin
        round_d = {RW{1'b0}};
        data_d  = merged_s;
        valid_d = 1'b1;
      end else begin
        round_d = round_q + {{(RW - 1){1'b0}}, 1'b1};
      end
    end else begin
      word_d = word_q;
    end
  end

  // Assembler and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_q <= {RW{1'b0}};
      word_q  <= {WORD_W{1'b0}};
      data_q  <= {WORD_W{1'b0}};
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      round_q <= round_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_phy_rx_lanes.sv
// Scoreboard bench for phy_rx_lanes (2 lanes, 32-bit words): serial streams are
// built per lane, expected words are queued when stimulus is built and checked on valid_out.
module tb_phy_rx_lanes;

  localparam logic [7:0] BC = 8'hBC;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_data_serie;
  logic [31:0] data_out;
  logic        valid_out;
  logic [1:0]  lane_active;
  logic        overflow_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        q0[$];
  logic        q1[$];
  logic [7:0]  pad_byte [2];
  int          pad_ph [2];

  always #5 clk = ~clk;

  phy_rx_lanes #(
    .LANES(2), .WORD_W(32), .COMMA(8'hBC), .SYNC_COUNT(4), .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data_serie(in_data_serie),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .lane_active  (lane_active),
    .overflow_err (overflow_err)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_byte(input int lane, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (lane == 0) q0.push_back(b[i]);
      else           q1.push_back(b[i]);
    end
  endtask

  task automatic add_rep(input int lane, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) add_byte(lane, b);
  endtask

  task automatic add_bits(input int lane, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (lane == 0) q0.push_back(v);
      else           q1.push_back(v);
    end
  endtask

  // Next bit for a lane; once its queue runs dry, the lane keeps sending its pad byte in frame.
  task automatic lane_bit(input int lane, output logic b);
    logic [7:0] p;
    if (lane == 0 && q0.size() > 0) begin
      b = q0.pop_front();
      pad_ph[0] = 0;
    end else if (lane == 1 && q1.size() > 0) begin
      b = q1.pop_front();
      pad_ph[1] = 0;
    end else begin
      p = pad_byte[lane];
      b = p[7 - pad_ph[lane]];
      pad_ph[lane] = (pad_ph[lane] + 1) % 8;
    end
  endtask

  task automatic step();
    logic b0, b1;
    lane_bit(0, b0);
    lane_bit(1, b1);
    in_data_serie = {b1, b0};
    @(negedge clk);
  endtask

  task automatic play();
    while (q0.size() > 0 || q1.size() > 0) step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    in_data_serie = 2'b00;
    q0.delete();
    q1.delete();
    pad_ph[0] = 0; pad_ph[1] = 0;
    pad_byte[0] = BC; pad_byte[1] = BC;
    repeat (2) @(negedge clk);
    check_value("rst_data", data_out, 32'h0);
    check_value("rst_valid", 32'(valid_out), 32'h0);
    check_value("rst_active", 32'(lane_active), 32'h0);
    check_value("rst_ovf", 32'(overflow_err), 32'h0);
    reset = 1'b1;
  endtask

  // Scoreboard: every valid_out cycle must match the oldest expected word
  always @(negedge clk) begin
    if (reset === 1'b1 && valid_out === 1'b1) begin
      if (exp_q.size() == 0) check_value("spurious_valid", 32'(valid_out), 32'h0);
      else                   check_value("word", data_out, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic
    do_reset();
    add_rep(0, BC, 3); add_rep(1, BC, 3); play();
    check_value("basic_pre_active", 32'(lane_active), 32'h0);
    add_byte(0, BC); add_byte(1, BC); play();
    check_value("basic_active", 32'(lane_active), 32'h3);
    add_byte(0, 8'h12); add_byte(0, 8'h56); add_byte(1, 8'h34); add_byte(1, 8'h78);
    exp_q.push_back(32'h12345678);
    play(); idle(16);
    check_value("basic_pending", 32'(exp_q.size()), 32'h0);

    // Bit skew: lane1 late by 3 bits plus one byte
    do_reset();
    add_rep(0, BC, 4); add_byte(0, 8'h12); add_byte(0, 8'h56);
    add_bits(1, 1'b0, 3); add_byte(1, 8'h00);
    add_rep(1, BC, 4); add_byte(1, 8'h34); add_byte(1, 8'h78);
    exp_q.push_back(32'h12345678);
    play(); idle(24);
    check_value("skew_ovf", 32'(overflow_err), 32'h0);
    check_value("skew_pending", 32'(exp_q.size()), 32'h0);

    // Idle insertion
    do_reset();
    add_rep(0, BC, 4); add_byte(0, 8'h12); add_rep(0, BC, 2); add_byte(0, 8'h56);
    add_rep(1, BC, 4); add_byte(1, 8'h34); add_byte(1, 8'h78); add_rep(1, BC, 2);
    exp_q.push_back(32'h12345678);
    play(); idle(16);
    check_value("idle_pending", 32'(exp_q.size()), 32'h0);

    // Sync failure: the broken comma run must restart qualification
    do_reset();
    add_rep(0, BC, 3); add_byte(0, 8'h00); add_rep(0, BC, 3);
    add_rep(1, BC, 7);
    play();
    check_value("syncfail_pre", 32'(lane_active), 32'h2);
    add_byte(0, BC); add_byte(1, BC); play();
    check_value("syncfail_post", 32'(lane_active), 32'h3);
    add_byte(0, 8'h12); add_byte(0, 8'h56); add_byte(1, 8'h34); add_byte(1, 8'h78);
    exp_q.push_back(32'h12345678);
    play(); idle(16);
    check_value("syncfail_pending", 32'(exp_q.size()), 32'h0);

    // Overflow with lane1 unsynced, then late sync of lane1
    do_reset();
    pad_byte[1] = 8'h00;
    add_rep(0, BC, 4);
    for (int i = 1; i <= 4; i++) add_byte(0, 8'(i));
    add_rep(1, 8'h00, 8);
    play();
    check_value("ovf_pre", 32'(overflow_err), 32'h0);
    add_byte(0, 8'h05); add_byte(1, 8'h00); play();
    check_value("ovf_set", 32'(overflow_err), 32'h1);
    check_value("ovf_active", 32'(lane_active), 32'h1);
    pad_byte[1] = BC;
    add_rep(0, BC, 4); add_rep(1, BC, 4); play();
    check_value("ovf_sync1", 32'(lane_active), 32'h3);
    add_rep(0, BC, 2); add_byte(1, 8'hAA); add_byte(1, 8'hBB);
    exp_q.push_back(32'h01AA02BB);
    play(); idle(16);
    check_value("ovf_sticky", 32'(overflow_err), 32'h1);
    check_value("ovf_pending", 32'(exp_q.size()), 32'h0);

    // Reset in the middle of a word
    do_reset();
    add_rep(0, BC, 4); add_rep(1, BC, 4);
    add_byte(0, 8'h11); add_byte(0, 8'h33); add_byte(1, 8'h22); add_byte(1, 8'h44);
    exp_q.push_back(32'h11223344);
    play(); idle(8);
    check_value("mid_hold", data_out, 32'h11223344);
    add_byte(0, 8'hDE); add_byte(1, 8'hAD); play(); idle(4);
    reset = 1'b0;
    #1;
    check_value("mid_data", data_out, 32'h0);
    check_value("mid_valid", 32'(valid_out), 32'h0);
    check_value("mid_active", 32'(lane_active), 32'h0);
    check_value("mid_ovf", 32'(overflow_err), 32'h0);
    do_reset();
    add_rep(0, BC, 4); add_rep(1, BC, 4);
    add_byte(0, 8'hDE); add_byte(0, 8'hBE); add_byte(1, 8'hAD); add_byte(1, 8'hEF);
    exp_q.push_back(32'hDEADBEEF);
    play(); idle(16);
    check_value("final_pending", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
